// File: rtl/apb_uart_regs_if.sv
// APB completer-side bus bundle for the UART register bank.
interface apb_uart_regs_if;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;

    modport master (output paddr, output pwdata, output psel, output penable, output pwrite,
                    input prdata);
    modport slave  (input paddr, input pwdata, input psel, input penable, input pwrite,
                    output prdata);
endinterface

// File: rtl/apb_uart_regs.sv
// Zero-wait-state APB register bank for a UART: control/interrupt registers
// plus TX (bus to serializer) and RX (deserializer to bus) FIFOs.
module apb_uart_regs #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_uart_regs_if.slave    apb,
    output logic              uart_int,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state_reg, state_next;

    logic        setup_fire, access_fire, wr_fire, rd_fire;
    logic [5:0]  reg_idx;
    logic [1:0]  ctrl_reg;
    logic [3:0]  int_en_reg, int_stat_reg, int_stat_next, hw_set, w1c;
    logic [31:0] prdata_reg, rd_mux, status;
    logic        uart_int_reg, tx_done;

    // Index 0 is the TX FIFO, index 1 the RX FIFO.
    logic [1:0]             push_req, push_ok, pop_req, fifo_full;
    logic [1:0][CW-1:0]     fifo_count;
    logic [1:0][DATA_W-1:0] fifo_head, push_data;

    logic unused_ok;
    assign unused_ok = ^{apb.paddr[31:8], apb.paddr[1:0], apb.pwdata[31:8]};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (apb.psel && !apb.penable) state_next = SETUP;
            SETUP:   if (!apb.psel) state_next = IDLE;
                     else if (apb.penable) state_next = ACCESS;
            ACCESS:  if (!apb.psel) state_next = IDLE;
                     else if (!apb.penable) state_next = SETUP;
            default: state_next = IDLE;
        endcase
    end

    // An access phase only counts when it directly follows a setup phase.
    always_comb begin
        setup_fire  = apb.psel && !apb.penable;
        access_fire = (state_reg == SETUP) && apb.psel && apb.penable;
        wr_fire     = access_fire && apb.pwrite;
        rd_fire     = access_fire && !apb.pwrite;
    end

    assign reg_idx = apb.paddr[7:2];

    assign tx_valid     = ctrl_reg[0] && (fifo_count[0] != '0);
    assign tx_data      = fifo_head[0];
    assign pop_req[0]   = tx_valid && tx_ready;
    assign push_req[0]  = wr_fire && (reg_idx == 6'd2);
    assign push_data[0] = apb.pwdata[DATA_W-1:0];
    assign pop_req[1]   = rd_fire && (reg_idx == 6'd3) && (fifo_count[1] != '0);
    assign push_req[1]  = rx_valid && ctrl_reg[1];
    assign push_data[1] = rx_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0]     count_reg;

            assign fifo_full[gi]  = (count_reg == CW'(FIFO_DEPTH));
            // A full FIFO still accepts a push when the head leaves in the same cycle.
            assign push_ok[gi]    = push_req[gi] && (!fifo_full[gi] || pop_req[gi]);
            assign fifo_count[gi] = count_reg;
            assign fifo_head[gi]  = mem[rd_ptr_reg];

            always_ff @(posedge pclk) begin
                if (push_ok[gi]) mem[wr_ptr_reg] <= push_data[gi];
            end

            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop_req[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({push_ok[gi], pop_req[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign tx_done = pop_req[0] && (fifo_count[0] == CW'(1)) && !push_ok[0];

    always_comb begin
        hw_set        = {push_req[1] && !push_ok[1], push_req[0] && !push_ok[0],
                         push_ok[1], tx_done};
        w1c           = (wr_fire && reg_idx == 6'd5) ? apb.pwdata[3:0] : 4'd0;
        int_stat_next = (int_stat_reg & ~w1c) | hw_set;
    end

    always_comb begin
        status        = '0;
        status[0]     = fifo_full[0];
        status[1]     = (fifo_count[0] == '0);
        status[2]     = fifo_full[1];
        status[3]     = (fifo_count[1] == '0);
        status[12:8]  = 5'(fifo_count[0]);
        status[20:16] = 5'(fifo_count[1]);
        rd_mux        = '0;
        case (reg_idx)
            6'd0:    rd_mux = {30'd0, ctrl_reg};
            6'd1:    rd_mux = status;
            6'd3:    rd_mux = (fifo_count[1] != '0) ? 32'(fifo_head[1]) : 32'd0;
            6'd4:    rd_mux = {28'd0, int_en_reg};
            6'd5:    rd_mux = {28'd0, int_stat_reg};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_reg     <= '0;
            int_en_reg   <= '0;
            int_stat_reg <= '0;
            prdata_reg   <= '0;
            uart_int_reg <= 1'b0;
        end else begin
            if (wr_fire && reg_idx == 6'd0) ctrl_reg   <= apb.pwdata[1:0];
            if (wr_fire && reg_idx == 6'd4) int_en_reg <= apb.pwdata[3:0];
            int_stat_reg <= int_stat_next;
            if (setup_fire && !apb.pwrite) prdata_reg <= rd_mux;
            uart_int_reg <= |(int_stat_reg & int_en_reg);
        end
    end

    assign apb.prdata = prdata_reg;
    assign uart_int   = uart_int_reg;
endmodule

// File: tb/tb_apb_uart_regs.sv
// Directed bench for apb_uart_regs: register table plus multi-cycle FIFO/IRQ sequences.
module tb_apb_uart_regs;
    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       uart_int, tx_valid, tx_ready, rx_valid;
    logic [7:0] tx_data, rx_data;
    int         total = 0;
    int         bad = 0;

    apb_uart_regs_if bus ();

    apb_uart_regs #(.FIFO_DEPTH(8), .DATA_W(8)) dut (
        .pclk(pclk), .presetn(presetn), .apb(bus), .uart_int(uart_int),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = addr; bus.pwdata = data;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        $display("wr %h <= %h", addr, data);
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        data = bus.prdata;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        $display("rd %h -> %h", addr, data);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;

        vecs[0]  = '{0, 32'h04, 32'h0, 32'h0000_000A};
        vecs[1]  = '{0, 32'h00, 32'h0, 32'h0};
        vecs[2]  = '{1, 32'h00, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{0, 32'h00, 32'h0, 32'h3};
        vecs[4]  = '{1, 32'h10, 32'hFF, 32'h0};
        vecs[5]  = '{0, 32'h10, 32'h0, 32'hF};
        vecs[6]  = '{0, 32'h08, 32'h0, 32'h0};
        vecs[7]  = '{0, 32'h14, 32'h0, 32'h0};
        vecs[8]  = '{1, 32'h18, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{0, 32'h18, 32'h0, 32'h0};
        vecs[10] = '{0, 32'h40, 32'h0, 32'h0};
        vecs[11] = '{0, 32'h100, 32'h0, 32'h3};
        vecs[12] = '{1, 32'h00, 32'h3, 32'h0};
        vecs[13] = '{1, 32'h10, 32'h1, 32'h0};

        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata", bus.prdata, 32'h0);
        check("rst_uart_int", {31'd0, uart_int}, 32'h0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        presetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
            else            rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // TX: three bytes, drained one pulse at a time
        apb_write(32'h08, 32'h41);
        apb_write(32'h08, 32'h42);
        apb_write(32'h08, 32'h43);
        rd_check("tx3_status", 32'h04, 32'h0000_0308);
        for (int i = 0; i < 3; i++) begin
            check("tx_valid_pulse", {31'd0, tx_valid}, 32'h1);
            check("tx_data_pulse", {24'd0, tx_data}, 32'h41 + i);
            tx_ready = 1'b1;
            @(posedge pclk); #1;
            tx_ready = 1'b0;
            check("uart_int_lag", {31'd0, uart_int}, 32'h0);
        end
        @(posedge pclk); #1;
        check("uart_int_set", {31'd0, uart_int}, 32'h1);
        check("tx_valid_drained", {31'd0, tx_valid}, 32'h0);
        rd_check("tx_done_stat", 32'h14, 32'h1);
        apb_write(32'h14, 32'h1);
        rd_check("tx_done_clr", 32'h14, 32'h0);

        // TX overflow: 9 writes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) apb_write(32'h08, 32'h10 + i);
        rd_check("tx_full_status", 32'h04, 32'h0000_0809);
        rd_check("tx_ovf_stat", 32'h14, 32'h4);
        check("uart_int_masked", {31'd0, uart_int}, 32'h0);
        apb_write(32'h14, 32'h4);
        rd_check("tx_ovf_clr", 32'h14, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("tx_drain_data", {24'd0, tx_data}, 32'h10 + i);
            @(posedge pclk); #1;
        end
        tx_ready = 1'b0;
        check("tx_9th_absent", {31'd0, tx_valid}, 32'h0);
        apb_write(32'h14, 32'h1);

        // RX: two pushes, two pops, then a read of the empty FIFO
        rx_data = 8'h5A; rx_valid = 1'b1;
        @(posedge pclk); #1;
        rx_data = 8'hA5;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        rd_check("rx2_status", 32'h04, 32'h0002_0002);
        rd_check("rx_avail", 32'h14, 32'h2);
        rd_check("rx_pop0", 32'h0C, 32'h5A);
        rd_check("rx_pop1", 32'h0C, 32'hA5);
        rd_check("rx_empty_status", 32'h04, 32'h0000_000A);
        rd_check("rx_pop_empty", 32'h0C, 32'h0);
        rd_check("rx_empty_again", 32'h04, 32'h0000_000A);
        apb_write(32'h14, 32'hF);
        apb_write(32'h00, 32'h1);
        rx_data = 8'h11; rx_valid = 1'b1;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        rd_check("rx_dis_status", 32'h04, 32'h0000_000A);
        rd_check("rx_dis_stat", 32'h14, 32'h0);
        apb_write(32'h00, 32'h3);

        // Back-to-back: TXDATA write then STATUS read with no idle cycle
        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h08; bus.pwdata = 32'h77;
        @(posedge pclk); #1;
        bus.penable = 1;
        @(posedge pclk); #1;
        bus.penable = 0; bus.pwrite = 0; bus.paddr = 32'h04;
        @(posedge pclk); #1;
        bus.penable = 1;
        check("b2b_status", bus.prdata, 32'h0000_0108);
        $display("b2b wr 08 <= 77, rd 04 -> %h", bus.prdata);
        @(posedge pclk); #1;
        bus.psel = 0; bus.penable = 0;
        check("b2b_head", {24'd0, tx_data}, 32'h77);

        // tx_done set in the same cycle as a W1C of bit 0
        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h14; bus.pwdata = 32'h1;
        @(posedge pclk); #1;
        bus.penable = 1; tx_ready = 1;
        @(posedge pclk); #1;
        bus.psel = 0; bus.penable = 0; tx_ready = 0;
        $display("collision wr 14 <= 1 with tx pop");
        rd_check("set_wins", 32'h14, 32'h1);
        check("collision_tx_valid", {31'd0, tx_valid}, 32'h0);
        apb_write(32'h14, 32'h1);
        rd_check("w1c_alone", 32'h14, 32'h0);

        // RX overflow: 9 pushes
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h80 + 8'(i);
            @(posedge pclk); #1;
        end
        rx_valid = 1'b0;
        rd_check("rx_full_status", 32'h04, 32'h0008_0006);
        rd_check("rx_ovf_stat", 32'h14, 32'hA);
        rd_check("rx_full_pop", 32'h0C, 32'h80);
        rd_check("rx_after_pop", 32'h04, 32'h0007_0002);

        // Reset asserted during a TXDATA access phase
        apb_write(32'h10, 32'hF);
        apb_write(32'h08, 32'h55);
        check("pre_rst_uart_int", {31'd0, uart_int}, 32'h1);
        @(posedge pclk); #1;
        bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 32'h08; bus.pwdata = 32'h66;
        @(posedge pclk); #1;
        bus.penable = 1;
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_prdata", bus.prdata, 32'h0);
        check("mid_rst_uart_int", {31'd0, uart_int}, 32'h0);
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        @(posedge pclk); #1;
        bus.psel = 0; bus.penable = 0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        $display("reset during TXDATA access");
        rd_check("post_rst_status", 32'h04, 32'h0000_000A);
        rd_check("post_rst_ctrl", 32'h00, 32'h0);
        rd_check("post_rst_int_en", 32'h10, 32'h0);
        rd_check("post_rst_int_stat", 32'h14, 32'h0);
        check("post_rst_tx_valid", {31'd0, tx_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
